// File: rtl/ring_input_channel.sv
// Ring input port: two single-entry VC buffers (even/odd). Accepts on the external-phase VC and
// requests deliver/continue from the internal-phase VC, with hop decrement on the way out.
module ring_input_channel #(
   parameter int unsigned PKT_W   = 64,
   parameter int unsigned VC_BIT  = 63,
   parameter int unsigned HOP_LSB = 48,
   parameter int unsigned HOP_W   = 8,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             polarity,
   input  logic             send_in,
   input  logic [PKT_W-1:0] data_in,
   output logic             ready_in,
   output logic             req_deliver,
   output logic             req_continue,
   output logic [PKT_W-1:0] data_out,
   input  logic             win_deliver,
   input  logic             win_continue,
   output logic [CNT_W-1:0] fwd_count,
   output logic             err
);

   // The VC tag must lie outside the hop field, and both must fit in the flit.
   if (VC_BIT >= PKT_W || HOP_LSB + HOP_W > PKT_W ||
       (VC_BIT >= HOP_LSB && VC_BIT < HOP_LSB + HOP_W)) begin : g_bad_layout
      $error("ring_input_channel: inconsistent flit field layout");
   end

   logic             full_even, full_odd;
   logic [PKT_W-1:0] data_even, data_odd;

   logic             ext_full, int_full;
   logic [PKT_W-1:0] int_data;
   logic [HOP_W-1:0] hop;
   logic             wr, grant, err_set;

   always_comb begin
      ext_full = polarity ? full_odd  : full_even;
      int_full = polarity ? full_even : full_odd;
      int_data = polarity ? data_even : data_odd;
      hop      = int_data[HOP_LSB +: HOP_W];

      ready_in     = reset && !ext_full;
      req_deliver  = int_full && (hop == '0);
      req_continue = int_full && (hop != '0);

      data_out = '0;
      if (int_full) begin
         data_out = int_data;
         if (hop != '0) data_out[HOP_LSB +: HOP_W] = hop - HOP_W'(1);
      end

      wr    = send_in && ready_in;
      // With both wins, one of them still matches the live request, so the entry is released.
      grant = (win_deliver && req_deliver) || (win_continue && req_continue);
      err_set = (win_deliver && !req_deliver) || (win_continue && !req_continue) ||
                (win_deliver && win_continue) || (send_in && !ready_in);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full_even <= 1'b0;
         full_odd  <= 1'b0;
         data_even <= '0;
         data_odd  <= '0;
         fwd_count <= '0;
         err       <= 1'b0;
      end else begin
         if (wr && !polarity) begin
            full_even <= 1'b1;
            data_even <= data_in;
         end else if (grant && polarity) begin
            full_even <= 1'b0;
         end

         if (wr && polarity) begin
            full_odd <= 1'b1;
            data_odd <= data_in;
         end else if (grant && !polarity) begin
            full_odd <= 1'b0;
         end

         if (grant && fwd_count != '1) fwd_count <= fwd_count + CNT_W'(1);
         if (err_set) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ring_input_channel.sv
// Scoreboard bench for ring_input_channel: stimulus pushes expected granted flits,
// a negedge monitor pops and compares on every matched grant.
module tb_ring_input_channel;

   logic        clk = 1'b0;
   logic        reset, polarity, send_in, win_deliver, win_continue;
   logic [63:0] data_in, data_out;
   logic        ready_in, req_deliver, req_continue, err;
   logic [15:0] fwd_count;

   typedef struct {
      logic [63:0] data;
      logic        deliver;
   } exp_t;

   exp_t q[$];
   int unsigned total = 0;
   int unsigned bad   = 0;

   ring_input_channel #(.PKT_W(64), .VC_BIT(63), .HOP_LSB(48), .HOP_W(8), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .polarity(polarity), .send_in(send_in), .data_in(data_in),
      .ready_in(ready_in), .req_deliver(req_deliver), .req_continue(req_continue),
      .data_out(data_out), .win_deliver(win_deliver), .win_continue(win_continue),
      .fwd_count(fwd_count), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] d, input logic dl);
      exp_t e;
      e.data = d;
      e.deliver = dl;
      q.push_back(e);
   endtask

   // Monitor: every matched grant is a transfer that must agree with the scoreboard.
   always @(negedge clk) begin
      if (reset && ((req_deliver && win_deliver) || (req_continue && win_continue))) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_grant: got data %h with empty scoreboard", data_out);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("grant_data", data_out, e.data);
            check("grant_kind_deliver", {63'd0, req_deliver}, {63'd0, e.deliver});
         end
      end
   end

   task automatic reset_pulse();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   localparam logic [63:0] A  = 64'h0003_1234_5678_9ABC;
   localparam logic [63:0] AO = 64'h0002_1234_5678_9ABC;
   localparam logic [63:0] B  = 64'h8000_0000_0000_00B0;
   localparam logic [63:0] C  = 64'h0005_0000_0000_00C0;
   localparam logic [63:0] CO = 64'h0004_0000_0000_00C0;
   localparam logic [63:0] D  = 64'h8001_0000_0000_00D0;
   localparam logic [63:0] DO = 64'h8000_0000_0000_00D0;
   localparam logic [63:0] E  = 64'h0000_0000_0000_00E0;
   localparam logic [63:0] F  = 64'h8002_0000_0000_00F0;
   localparam logic [63:0] FO = 64'h8001_0000_0000_00F0;
   localparam logic [63:0] G  = 64'h00FF_0000_0000_0A0A;
   localparam logic [63:0] GO = 64'h00FE_0000_0000_0A0A;
   localparam logic [63:0] H  = 64'h0007_0000_0000_0B0B;

   initial begin
      reset = 1'b0; polarity = 1'b0; send_in = 1'b0; data_in = '0;
      win_deliver = 1'b0; win_continue = 1'b0;
      tick(); tick();
      check("rst_ready_in", {63'd0, ready_in}, 64'd0);
      check("rst_reqs", {62'd0, req_deliver, req_continue}, 64'd0);
      check("rst_data_out", data_out, 64'd0);
      check("rst_fwd_count", {48'd0, fwd_count}, 64'd0);
      check("rst_err", {63'd0, err}, 64'd0);
      reset = 1'b1;
      #1;
      check("post_rst_ready_in", {63'd0, ready_in}, 64'd1);

      // hop 3 flit, continue path
      send_in = 1'b1; data_in = A;
      tick();
      send_in = 1'b0;
      check("a_ready_full", {63'd0, ready_in}, 64'd0);
      check("a_no_req_same_phase", {62'd0, req_deliver, req_continue}, 64'd0);
      polarity = 1'b1;
      #1;
      check("a_req_continue", {62'd0, req_deliver, req_continue}, 64'd1);
      check("a_data_out", data_out, AO);
      check("a_ready_odd_empty", {63'd0, ready_in}, 64'd1);
      win_continue = 1'b1; push(AO, 1'b0);
      tick();
      win_continue = 1'b0;
      check("a_released", {62'd0, req_deliver, req_continue}, 64'd0);
      check("a_fwd_count", {48'd0, fwd_count}, 64'd1);

      // hop 0 flit, deliver path, odd VC
      send_in = 1'b1; data_in = B;
      tick();
      send_in = 1'b0;
      polarity = 1'b0;
      #1;
      check("b_req_deliver", {62'd0, req_deliver, req_continue}, 64'd2);
      check("b_data_out", data_out, B);
      win_deliver = 1'b1; push(B, 1'b1);
      tick();
      win_deliver = 1'b0;
      check("b_released", {62'd0, req_deliver, req_continue}, 64'd0);
      check("b_fwd_count", {48'd0, fwd_count}, 64'd2);

      // write and grant in the same cycle
      send_in = 1'b1; data_in = C;
      tick();
      polarity = 1'b1; data_in = D; win_continue = 1'b1; push(CO, 1'b0);
      tick();
      send_in = 1'b0; win_continue = 1'b0;
      check("cd_ready_odd_full", {63'd0, ready_in}, 64'd0);
      check("cd_even_released", {62'd0, req_deliver, req_continue}, 64'd0);
      check("cd_fwd_count", {48'd0, fwd_count}, 64'd3);
      polarity = 1'b0;
      #1;
      check("d_data_out", data_out, DO);
      win_continue = 1'b1; push(DO, 1'b0);
      tick();
      win_continue = 1'b0;
      check("d_fwd_count", {48'd0, fwd_count}, 64'd4);
      check("no_err_yet", {63'd0, err}, 64'd0);

      // mismatched win: flagged, buffer kept
      send_in = 1'b1; data_in = E;
      tick();
      send_in = 1'b0; polarity = 1'b1; win_continue = 1'b1;
      tick();
      win_continue = 1'b0;
      check("mismatch_err", {63'd0, err}, 64'd1);
      check("mismatch_kept", {62'd0, req_deliver, req_continue}, 64'd2);
      win_deliver = 1'b1; push(E, 1'b1);
      tick();
      win_deliver = 1'b0;
      check("err_sticky", {63'd0, err}, 64'd1);
      check("e_fwd_count", {48'd0, fwd_count}, 64'd5);

      // both wins together: error, buffer still clears
      reset_pulse();
      #1;
      check("rst2_err", {63'd0, err}, 64'd0);
      check("rst2_fwd", {48'd0, fwd_count}, 64'd0);
      send_in = 1'b1; data_in = F;
      tick();
      send_in = 1'b0; polarity = 1'b0;
      win_continue = 1'b1; win_deliver = 1'b1; push(FO, 1'b0);
      tick();
      win_continue = 1'b0; win_deliver = 1'b0;
      check("both_wins_err", {63'd0, err}, 64'd1);
      check("both_wins_cleared", {62'd0, req_deliver, req_continue}, 64'd0);

      // dropped write: error, stored flit untouched
      reset_pulse();
      send_in = 1'b1; data_in = G;
      tick();
      data_in = H;
      tick();
      send_in = 1'b0;
      check("drop_err", {63'd0, err}, 64'd1);
      check("drop_ready", {63'd0, ready_in}, 64'd0);
      polarity = 1'b1;
      #1;
      check("drop_kept_data", data_out, GO);
      win_continue = 1'b1; push(GO, 1'b0);
      tick();
      win_continue = 1'b0;

      // asynchronous reset mid-hold
      reset_pulse();
      send_in = 1'b1; data_in = H;
      tick();
      send_in = 1'b0; polarity = 1'b0;
      #1;
      check("h_req", {62'd0, req_deliver, req_continue}, 64'd1);
      #1;
      reset = 1'b0;
      #1;
      check("async_rst_reqs", {62'd0, req_deliver, req_continue}, 64'd0);
      check("async_rst_data", data_out, 64'd0);
      check("async_rst_ready", {63'd0, ready_in}, 64'd0);
      tick();
      reset = 1'b1;
      #1;
      check("async_rst_empty", {62'd0, req_deliver, req_continue}, 64'd0);

      // saturation: one write and one grant per cycle, alternating phase
      for (int k = 0; k <= 65536; k++) begin
         logic [63:0] fl;
         fl = {63'd0, 1'b0};
         fl[63] = k[0];
         fl[55:48] = 8'h01;
         fl[31:0] = k;
         polarity = k[0];
         send_in = (k < 65536);
         data_in = fl;
         win_continue = (k > 0);
         if (k > 0) begin
            logic [63:0] pv;
            pv = '0;
            pv[63] = ~k[0];
            pv[31:0] = k - 1;
            push(pv, 1'b0);
         end
         tick();
         if (k == 65535) check("sat_reach_max", {48'd0, fwd_count}, 64'hFFFF);
      end
      send_in = 1'b0; win_continue = 1'b0;
      check("sat_hold_max", {48'd0, fwd_count}, 64'hFFFF);
      check("sat_no_err", {63'd0, err}, 64'd0);
      check("sat_drained", {62'd0, req_deliver, req_continue}, 64'd0);

      tick(); tick();
      check("scoreboard_empty", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ring_input_channel.md
Name: ring_input_channel

Overview:
- Requester side of the router's 2-input output arbiters: one per ring input port (CW_in or CCW_in) of a router.
- Buffers incoming flits in two single-entry virtual-channel (VC) buffers, even and odd, and accepts from the link on the external-phase VC.
- Raises either a deliver request (to the PE_out arbiter) or a continue request (to the same-direction output arbiter) from the internal-phase VC, and releases the entry when granted.

Parameters:
- PKT_W, 64, flit width in bits.
- VC_BIT, 63, bit index of the VC tag in the flit; 0 = even, 1 = odd.
- HOP_LSB, 48, LSB of the hop-count field.
- HOP_W, 8, hop-count field width.
- CNT_W, 16, width of the forwarded-flit statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- polarity  in  1  router phase; 0: even VC external, odd VC internal; 1: the reverse.
- send_in  in  1  upstream valid.
- data_in  in  PKT_W  upstream flit.
- ready_in  out  1  external VC buffer empty.
- req_deliver  out  1  request to the PE_out arbiter.
- req_continue  out  1  request to the ring-direction output arbiter.
- data_out  out  PKT_W  internal VC flit, hop field decremented.
- win_deliver  in  1  grant from the PE_out arbiter.
- win_continue  in  1  grant from the ring-output arbiter.
- fwd_count  out  CNT_W  saturating count of granted flits.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (reset low, asynchronous):
  - Both VC buffers empty, data registers 0.
  - fwd_count = 0, err = 0.
  - All outputs 0 during reset, except ready_in, which is also 0 while reset is held.
- ready_in = reset deasserted AND the external VC (the even VC when polarity = 0, else the odd VC) is empty. It is combinational from state and polarity.
- Write:
  - A write occurs when send_in && ready_in. The flit is stored into the external VC at the edge, and that VC is marked full.
  - The flit's VC_BIT is not checked against polarity; upstream is responsible for it.
  - send_in while ready_in = 0 is dropped and sets err.
- Requests, from the internal VC only:
  - req_deliver = full && hop == 0.
  - req_continue = full && hop != 0.
  - At most one request is ever asserted. Both are 0 when the internal VC is empty.
- data_out:
  - Equals the internal flit with the hop field replaced by hop-1 (modulo 2^HOP_W) when hop != 0.
  - When hop == 0 the flit passes unmodified.
  - data_out is 0 when the internal VC is empty.
- Grant:
  - A win matching the asserted request clears the internal VC at the next edge.
  - Latency: a flit written in phase p is requestable in phase !p. A grant in cycle t leaves the buffer empty at t+1.
- Errors: err is set (sticky until reset) on any of:
  - a win on a port not requested;
  - both wins in the same cycle (the buffer still clears);
  - a dropped write.
- fwd_count increments by 1 on each valid grant and saturates at 2^CNT_W-1.
- Polarity toggle:
  - Buffer contents are unaffected; only the external/internal roles swap.
  - Requests and ready_in follow the new polarity in the same cycle.
  - An ungranted internal flit becomes external and holds ready_in low until it is granted in a later phase.
- A write and a grant in the same cycle target different VCs, so both take effect.
- Reset asserted mid-operation discards buffered flits immediately; there is no partial grant.

Test Plan:
- Reset → ready_in 0, then 1 after release with polarity = 0. Requests 0, fwd_count 0, err 0.
- polarity 0, write flit with hop 3 → even VC full, ready_in 0. Toggle polarity to 1 → req_continue 1, data_out hop = 2, ready_in 1 (odd VC empty). win_continue → even VC empty next cycle, fwd_count = 1.
- Flit with hop 0 made internal → req_deliver 1, req_continue 0, data_out equals the stored flit. win_deliver → released.
- Same cycle: write into the external VC and grant the internal VC → both occur; the next phase requests the new flit.
- win_continue while req_deliver is asserted, or both wins together → err = 1 and stays 1 until reset.
- Preload fwd_count to 0xFFFF via 65535 grants (or force) → an additional grant leaves 0xFFFF. Assert reset mid-hold → all state cleared immediately.
